// File: rtl/irq_entry_sequencer_if.sv
// Signal bundle between irq_entry_sequencer, the interrupt controller and the core pipeline.
// The master modport is the sequencer side; slave is the controller/pipeline side.
interface irq_entry_sequencer_if #(
  parameter int PC_WIDTH     = 32,
  parameter int VECTOR_WIDTH = 8,
  parameter int NEST_DEPTH   = 4
);
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

  logic                    irq_pending;
  logic [3:0]              irq_num;
  logic [VECTOR_WIDTH-1:0] irq_vector;
  logic                    irq_ack;
  logic [3:0]              irq_ack_num;
  logic                    eoi_valid;
  logic [3:0]              eoi_num;
  logic                    pipe_stall;
  logic                    pipe_empty;
  logic                    pipe_flush;
  logic [PC_WIDTH-1:0]     retire_pc;
  logic                    ret_req;
  logic                    redirect_valid;
  logic [PC_WIDTH-1:0]     redirect_pc;
  logic                    redirect_ready;
  logic                    gie_set;
  logic                    gie_clr;
  logic                    gie;
  logic [DEPTH_W-1:0]      depth;
  logic                    busy;
  logic                    ret_err;

  modport master (
    input  irq_pending, irq_num, irq_vector, pipe_empty, retire_pc, ret_req,
           redirect_ready, gie_set, gie_clr,
    output irq_ack, irq_ack_num, eoi_valid, eoi_num, pipe_stall, pipe_flush,
           redirect_valid, redirect_pc, gie, depth, busy, ret_err
  );

  modport slave (
    output irq_pending, irq_num, irq_vector, pipe_empty, retire_pc, ret_req,
           redirect_ready, gie_set, gie_clr,
    input  irq_ack, irq_ack_num, eoi_valid, eoi_num, pipe_stall, pipe_flush,
           redirect_valid, redirect_pc, gie, depth, busy, ret_err
  );
endinterface

// File: rtl/irq_entry_sequencer.sv
// Interrupt entry/exit sequencer: drain, ack, save resume PC, redirect; pop and EOI on return.
// Define IRQ_NEST_EN to allow nesting up to NEST_DEPTH; otherwise a single save register is used.
module irq_entry_sequencer #(
  parameter int PC_WIDTH     = 32,
  parameter int VECTOR_WIDTH = 8,
  parameter int NEST_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irq_entry_sequencer_if.master bus
);
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
`ifdef IRQ_NEST_EN
  localparam int EFF_DEPTH = NEST_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {IDLE, DRAIN, ACK, REDIRECT} state_t;

  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q;
  logic                gie_q;
  logic [PC_WIDTH-1:0] redirect_pc_q;
  logic [3:0]          eoi_num_q;
  logic                ret_done_q;
  logic                ret_err_q;
  logic                do_return;
  logic                do_ret_err;
  logic                do_push;
  logic                can_enter;
  logic [PC_WIDTH-1:0] top_pc;
  logic [3:0]          top_num;

  assign can_enter = gie_q && (depth_q < DEPTH_W'(EFF_DEPTH));

`ifdef IRQ_NEST_EN
  localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [PC_WIDTH-1:0] pc_stack  [2**IDX_W];
  logic [3:0]          num_stack [2**IDX_W];
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    top_idx;

  assign push_idx = IDX_W'(depth_q);
  assign top_idx  = IDX_W'(depth_q - DEPTH_W'(1));
  assign top_pc   = pc_stack[top_idx];
  assign top_num  = num_stack[top_idx];

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      pc_stack[push_idx]  <= bus.retire_pc;
      num_stack[push_idx] <= bus.irq_num;
    end
  end
`else
  logic [PC_WIDTH-1:0] saved_pc;
  logic [3:0]          saved_num;

  assign top_pc  = saved_pc;
  assign top_num = saved_num;

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      saved_pc  <= bus.retire_pc;
      saved_num <= bus.irq_num;
    end
  end
`endif

  // Return has priority over a new entry; a return spends one cycle flushing before redirecting.
  always_comb begin
    state_d    = state_q;
    do_return  = 1'b0;
    do_ret_err = 1'b0;
    do_push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ret_req && (depth_q != '0)) begin
          do_return = 1'b1;
          state_d   = REDIRECT;
        end else if (bus.ret_req) begin
          do_ret_err = 1'b1;
        end else if (bus.irq_pending && can_enter) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.irq_pending)    state_d = IDLE;
        else if (bus.pipe_empty) state_d = ACK;
      end
      ACK: begin
        do_push = 1'b1;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready && !ret_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      depth_q       <= '0;
      gie_q         <= 1'b0;
      redirect_pc_q <= '0;
      eoi_num_q     <= '0;
      ret_done_q    <= 1'b0;
      ret_err_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_done_q <= do_return;
      ret_err_q  <= do_ret_err;
      if (do_push) begin
        depth_q       <= depth_q + DEPTH_W'(1);
        redirect_pc_q <= PC_WIDTH'({bus.irq_vector, 2'b00});
      end else if (do_return) begin
        depth_q       <= depth_q - DEPTH_W'(1);
        redirect_pc_q <= top_pc;
        eoi_num_q     <= top_num;
      end
      // Entry/return updates beat software writes; clear beats set.
      if (do_push)          gie_q <= 1'b0;
      else if (do_return)   gie_q <= 1'b1;
      else if (bus.gie_clr) gie_q <= 1'b0;
      else if (bus.gie_set) gie_q <= 1'b1;
    end
  end

  // Pulses are masked while reset is held so an abandoned sequence never emits ack or EOI.
  assign bus.irq_ack        = rst_n && (state_q == ACK);
  assign bus.irq_ack_num    = (state_q == ACK) ? bus.irq_num : 4'd0;
  assign bus.eoi_valid      = rst_n && ret_done_q;
  assign bus.eoi_num        = eoi_num_q;
  assign bus.pipe_flush     = rst_n && ((state_q == ACK) || ret_done_q);
  assign bus.pipe_stall     = (state_q != IDLE);
  assign bus.redirect_valid = (state_q == REDIRECT) && !ret_done_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.gie            = gie_q;
  assign bus.depth          = depth_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.ret_err        = rst_n && ret_err_q;
endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Self-checking bench for irq_entry_sequencer: directed steps with random payloads
// checked against a save-stack/gie reference model.
`timescale 1ns/1ps
module tb_irq_entry_sequencer;
  localparam int PC_WIDTH     = 32;
  localparam int VECTOR_WIDTH = 8;
  localparam int NEST_DEPTH   = 4;
`ifdef IRQ_NEST_EN
  localparam int EFF_DEPTH = NEST_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  irq_entry_sequencer_if #(
    .PC_WIDTH(PC_WIDTH), .VECTOR_WIDTH(VECTOR_WIDTH), .NEST_DEPTH(NEST_DEPTH)
  ) bus ();

  irq_entry_sequencer #(
    .PC_WIDTH(PC_WIDTH), .VECTOR_WIDTH(VECTOR_WIDTH), .NEST_DEPTH(NEST_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int fail_cnt  = 0;

  // Reference model: LIFO of saved (pc, num) pairs plus the global enable bit.
  logic [PC_WIDTH-1:0] stk_pc  [$];
  logic [3:0]          stk_num [$];
  logic                model_gie = 1'b0;

  function automatic bit allowed();
    return model_gie && (stk_num.size() < EFF_DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt = check_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic pend, input logic [3:0] num,
                               input logic [VECTOR_WIDTH-1:0] vec, input logic empty,
                               input logic [PC_WIDTH-1:0] pc);
    bus.irq_pending = pend;
    bus.irq_num     = num;
    bus.irq_vector  = vec;
    bus.pipe_empty  = empty;
    bus.retire_pc   = pc;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 4'd0, '0, 1'b1, '0);
    bus.ret_req        = 1'b0;
    bus.redirect_ready = 1'b0;
    bus.gie_set        = 1'b0;
    bus.gie_clr        = 1'b0;
  endtask

  task automatic setGie(input logic s, input logic c);
    bus.gie_set = s;
    bus.gie_clr = c;
    tick();
    bus.gie_set = 1'b0;
    bus.gie_clr = 1'b0;
    if (c)      model_gie = 1'b0;
    else if (s) model_gie = 1'b1;
    checkOutput("gie_write", bus.gie, model_gie);
  endtask

  task automatic waitRedirect(input logic [PC_WIDTH-1:0] exp_pc, input int dly);
    checkOutput("redir_valid", bus.redirect_valid, 1);
    checkOutput("redir_pc", bus.redirect_pc, exp_pc);
    for (int i = 0; i < dly; i++) begin
      tick();
      checkOutput("redir_hold_valid", bus.redirect_valid, 1);
      checkOutput("redir_hold_pc", bus.redirect_pc, exp_pc);
      checkOutput("redir_stall", bus.pipe_stall, 1);
    end
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    checkOutput("post_redir_valid", bus.redirect_valid, 0);
    checkOutput("post_redir_busy", bus.busy, 0);
    checkOutput("post_redir_stall", bus.pipe_stall, 0);
  endtask

  task automatic enterIrq(input logic [3:0] num, input logic [VECTOR_WIDTH-1:0] vec,
                          input logic [PC_WIDTH-1:0] pc, input int drain, input int dly);
    logic [PC_WIDTH-1:0] tgt;
    tgt = vec * 4;
    applyStimulus(1'b1, num, vec, drain == 0, pc);
    #1 checkOutput("entry_idle_busy", bus.busy, 0);
    tick();
    for (int i = 0; i < drain; i++) begin
      checkOutput("drain_stall", bus.pipe_stall, 1);
      checkOutput("drain_no_ack", bus.irq_ack, 0);
      tick();
    end
    bus.pipe_empty = 1'b1;
    #1 checkOutput("drain_last_stall", bus.pipe_stall, 1);
    tick();
    checkOutput("ack_pulse", bus.irq_ack, 1);
    checkOutput("ack_num", bus.irq_ack_num, num);
    checkOutput("ack_flush", bus.pipe_flush, 1);
    checkOutput("ack_stall", bus.pipe_stall, 1);
    stk_pc.push_back(pc);
    stk_num.push_back(num);
    model_gie = 1'b0;
    bus.irq_pending = 1'b0;
    tick();
    checkOutput("entry_ack_gone", bus.irq_ack, 0);
    checkOutput("entry_flush_gone", bus.pipe_flush, 0);
    checkOutput("entry_gie", bus.gie, 0);
    checkOutput("entry_depth", bus.depth, stk_num.size());
    waitRedirect(tgt, dly);
  endtask

  task automatic doReturn(input int dly);
    logic [PC_WIDTH-1:0] exp_pc;
    logic [3:0]          exp_num;
    bus.ret_req = 1'b1;
    tick();
    bus.ret_req     = 1'b0;
    bus.irq_pending = 1'b0;
    if (stk_num.size() == 0) begin
      checkOutput("ret_err_pulse", bus.ret_err, 1);
      checkOutput("ret_err_no_eoi", bus.eoi_valid, 0);
      checkOutput("ret_err_busy", bus.busy, 0);
      tick();
      checkOutput("ret_err_gone", bus.ret_err, 0);
    end else begin
      exp_pc    = stk_pc.pop_back();
      exp_num   = stk_num.pop_back();
      model_gie = 1'b1;
      checkOutput("eoi_valid", bus.eoi_valid, 1);
      checkOutput("eoi_num", bus.eoi_num, exp_num);
      checkOutput("ret_flush", bus.pipe_flush, 1);
      checkOutput("ret_not_yet_redir", bus.redirect_valid, 0);
      checkOutput("ret_no_ack", bus.irq_ack, 0);
      checkOutput("ret_gie", bus.gie, 1);
      checkOutput("ret_depth", bus.depth, stk_num.size());
      tick();
      checkOutput("eoi_gone", bus.eoi_valid, 0);
      waitRedirect(exp_pc, dly);
    end
  endtask

  task automatic checkBlocked();
    applyStimulus(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b1, $urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("blocked_busy", bus.busy, 0);
      checkOutput("blocked_no_ack", bus.irq_ack, 0);
    end
    bus.irq_pending = 1'b0;
    checkOutput("blocked_depth", bus.depth, stk_num.size());
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_gie", bus.gie, 0);
    checkOutput("rst_depth", bus.depth, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_stall", bus.pipe_stall, 0);
    checkOutput("rst_redir", bus.redirect_valid, 0);
    checkOutput("rst_ack", bus.irq_ack, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic entry and blocked entry while gie=0");
    setGie(1'b1, 1'b0);
    enterIrq(4'd5, 8'h40, 32'h1000, 0, 0);
    checkBlocked();

    $display("[TB] return, then return at depth 0");
    doReturn(2);
    doReturn(0);

    $display("[TB] simultaneous gie set/clear");
    setGie(1'b1, 1'b1);
    setGie(1'b1, 1'b0);

    $display("[TB] drained entry with delayed redirect_ready");
    enterIrq(4'd3, 8'($urandom), $urandom, 4, 3);

    $display("[TB] nesting up to the effective depth");
    for (int i = 0; i < NEST_DEPTH; i++) begin
      setGie(1'b1, 1'b0);
      if (allowed())
        enterIrq((i == 0) ? 4'd1 : 4'($urandom_range(0, 15)), 8'($urandom), $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 2));
      else
        checkBlocked();
    end
    while (stk_num.size() > 0) doReturn($urandom_range(0, 2));

    $display("[TB] spurious drop during drain");
    applyStimulus(1'b1, 4'd7, 8'h11, 1'b0, 32'h2000);
    tick();
    checkOutput("spur_stall", bus.pipe_stall, 1);
    tick();
    bus.irq_pending = 1'b0;
    tick();
    checkOutput("spur_busy", bus.busy, 0);
    checkOutput("spur_no_ack", bus.irq_ack, 0);
    checkOutput("spur_depth", bus.depth, stk_num.size());

    $display("[TB] reset during ack");
    applyStimulus(1'b1, 4'd9, 8'h22, 1'b1, 32'h3000);
    tick();
    tick();
    rst_n = 1'b0;
    #1 checkOutput("rst_mid_no_ack", bus.irq_ack, 0);
    checkOutput("rst_mid_no_flush", bus.pipe_flush, 0);
    tick();
    stk_pc.delete();
    stk_num.delete();
    model_gie = 1'b0;
    checkOutput("rst_mid_busy", bus.busy, 0);
    checkOutput("rst_mid_depth", bus.depth, 0);
    checkOutput("rst_mid_gie", bus.gie, 0);
    rst_n = 1'b1;
    clearInputs();
    tick();

    $display("[TB] ret_req with irq_pending at depth 0, then at depth 1");
    setGie(1'b1, 1'b0);
    bus.ret_req = 1'b1;
    applyStimulus(1'b1, 4'd12, 8'h33, 1'b1, 32'h4000);
    tick();
    bus.ret_req = 1'b0;
    checkOutput("sim0_ret_err", bus.ret_err, 1);
    checkOutput("sim0_busy", bus.busy, 0);
    enterIrq(4'd12, 8'h33, 32'h4000, 0, 0);
    setGie(1'b1, 1'b0);
    bus.irq_pending = 1'b1;
    doReturn(1);

    $display("[TB] randomized entry/return rounds");
    for (int r = 0; r < 4; r++) begin
      setGie(1'b1, 1'b0);
      enterIrq(4'($urandom_range(0, 15)), 8'($urandom), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3));
      setGie(1'b1, 1'b0);
      if (allowed())
        enterIrq(4'($urandom_range(0, 15)), 8'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        checkBlocked();
      while (stk_num.size() > 0) doReturn($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/irq_entry_sequencer.md
Name: irq_entry_sequencer

Overview:
Sequences CPU entry into and exit from interrupt handlers for the interrupt pipeline. It sits between the vectored interrupt controller and the core pipeline. On entry it stalls fetch, drains in-flight instructions, acknowledges the IRQ, saves the resume PC on a nesting stack and redirects fetch to the vector. On return it pops the stack, issues end-of-interrupt (EOI) to the controller and redirects back to the saved PC.

Parameters:
PC_WIDTH, 32, width of program counter / resume PC
VECTOR_WIDTH, 8, width of irq_vector from controller
NEST_DEPTH, 4, save-stack entries (max nesting level); must be >= 1

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
irq_pending  input  1  controller has enabled, unserviced IRQ
irq_num  input  4  highest-priority IRQ number
irq_vector  input  VECTOR_WIDTH  vector for irq_num
irq_ack  output  1  one-cycle acknowledge pulse to controller
irq_ack_num  output  4  IRQ being acknowledged
eoi_valid  output  1  one-cycle end-of-interrupt pulse
eoi_num  output  4  IRQ number completing
pipe_stall  output  1  hold fetch and issue
pipe_empty  input  1  no instructions in flight
pipe_flush  output  1  one-cycle flush of front-end
retire_pc  input  PC_WIDTH  PC of next instruction to execute (resume point)
ret_req  input  1  return-from-interrupt retiring (one-cycle pulse)
redirect_valid  output  1  fetch redirect request
redirect_pc  output  PC_WIDTH  redirect target
redirect_ready  input  1  fetch accepted redirect
gie_set  input  1  software sets global interrupt enable
gie_clr  input  1  software clears global interrupt enable
gie  output  1  global interrupt enable
depth  output  $clog2(NEST_DEPTH+1)  current nesting level
busy  output  1  FSM not in IDLE
ret_err  output  1  one-cycle pulse: ret_req with depth==0

Behaviour:
- Reset (rst_n low at posedge clk): FSM=IDLE. All outputs 0 except gie=0. depth=0. Stack contents don't-care.
- FSM states: IDLE, DRAIN, ACK, REDIRECT.
- IDLE, priority order:
  - ret_req && depth>0: pop top entry. Pulse eoi_valid with eoi_num=entry.num. gie<=1. Pulse pipe_flush. Load redirect target = entry.pc. Go to REDIRECT.
  - ret_req && depth==0: pulse ret_err, stay in IDLE.
  - else irq_pending && gie && depth<NEST_DEPTH: go to DRAIN.
- gie_set/gie_clr act in any state. If both asserted, clr wins. Entry/return updates to gie override both in the same cycle.
- DRAIN: pipe_stall=1.
  - pipe_empty && irq_pending: go to ACK.
  - !irq_pending (spurious, line dropped): go to IDLE, no ack, no stack change.
- ACK (exactly one cycle), with pipe_stall=1:
  - irq_ack=1, irq_ack_num=irq_num sampled this cycle.
  - Push {retire_pc, irq_num}; depth+1.
  - gie<=0; pipe_flush=1.
  - redirect target = zero-extended {irq_vector, 2'b00}, truncated to PC_WIDTH.
  - Go to REDIRECT.
- REDIRECT: pipe_stall=1, redirect_valid=1, redirect_pc held stable. When redirect_ready is seen, go to IDLE; redirect_valid drops the next cycle.
- Latencies:
  - irq_pending with pipe_empty already high: irq_ack 2 cycles after IDLE sample, redirect_valid 3 cycles after.
  - ret_req: eoi_valid on the next cycle, redirect_valid 1 cycle after that.
- ret_req outside IDLE is ignored; the core guarantees stall during those states.
- busy = (state != IDLE).
- Reset mid-sequence: abandon immediately. No ack or eoi is emitted.

Optional Feature:
IRQ_NEST_EN. When defined, NEST_DEPTH is honoured and nested entry is allowed once the handler executes gie_set. When undefined, effective depth is 1: no IRQ entry while depth==1 regardless of gie, and the stack is a single register.

Test Plan:
- Basic entry, pipe_empty=1: reset; gie_set; irq_pending=1, irq_num=5, irq_vector=8'h40, retire_pc=32'h1000 -> irq_ack pulse with irq_ack_num=5, pipe_flush same cycle, redirect_pc=32'h100, gie=0, depth=1.
- Drain wait: pipe_empty low for 4 cycles after irq -> pipe_stall high throughout, irq_ack only after pipe_empty rises; redirect_ready delayed 3 cycles -> redirect_valid/pc held stable.
- Return: after entry, ret_req pulse -> eoi_valid with eoi_num=5, redirect_pc=32'h1000, gie=1, depth=0. ret_req at depth 0 -> ret_err pulse, no eoi.
- Spurious: irq_pending drops during DRAIN -> back to IDLE, no irq_ack, depth unchanged.
- Nesting (IRQ_NEST_EN): enter IRQ 3, gie_set, enter IRQ 1, fill to NEST_DEPTH=4 -> fifth pending IRQ not taken. Returns produce EOI order 1 then 3 with correct PCs.
- Simultaneous: ret_req and irq_pending in IDLE -> return taken first. gie_set+gie_clr together -> gie=0.
